// File: rtl/range_doppler_transpose_reader.sv
// Corner-turn reader: walks a chirp-major frame buffer in sample-major order and streams it out.
// Latency: first word 3 cycles after start. Backpressure: 2-entry output FIFO, reads stall when full.
module range_doppler_transpose_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CHIRPS  = 16,
    parameter int NUM_SAMPLES = 16,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_abort,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_ram_en,
    output logic [ADDR_WIDTH-1:0]          o_ram_addr,
    input  logic [DATA_WIDTH-1:0]          i_ram_dout,
    output logic [DATA_WIDTH-1:0]          o_m_data,
    output logic                           o_m_valid,
    input  logic                           i_m_ready,
    output logic                           o_m_col_last,
    output logic                           o_m_frame_last,
    output logic [$clog2(NUM_SAMPLES)-1:0] o_m_col_idx
);

    localparam int SW = $clog2(NUM_SAMPLES);
    localparam int CW = $clog2(NUM_CHIRPS);
    localparam logic [CW-1:0]         C_LAST = CW'(NUM_CHIRPS - 1);
    localparam logic [SW-1:0]         S_LAST = SW'(NUM_SAMPLES - 1);
    localparam logic [CW-1:0]         C_ONE  = CW'(1);
    localparam logic [SW-1:0]         S_ONE  = SW'(1);
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_STEP = ADDR_WIDTH'(NUM_SAMPLES);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [SW-1:0]         col;
        logic                  col_last;
        logic                  frame_last;
    } entry_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_s;
    logic [CW-1:0]         r_c;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_inflight;
    logic [SW-1:0]         r_pend_s;
    logic                  r_pend_col_last;
    logic                  r_pend_frame_last;
    entry_t                r_head;
    entry_t                r_tail;
    logic                  r_h_vld;
    logic                  r_t_vld;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_last_rd;
    logic                  w_done;
    logic                  w_start;
    logic [2:0]            w_load;
    entry_t                w_new;

    assign w_pop     = r_h_vld & i_m_ready;
    assign w_push    = r_inflight;
    assign w_last_rd = (r_c == C_LAST) && (r_s == S_LAST);
    assign w_start   = (r_state == ST_IDLE) && i_start && !i_abort;
    // Words issued but not yet consumed: FIFO contents plus the read still inside the RAM.
    assign w_load    = 3'(r_h_vld) + 3'(r_t_vld) + 3'(r_inflight);
    assign w_issue   = (r_state == ST_RUN) && !i_abort && (w_load < (3'd2 + 3'(w_pop)));
    assign w_done    = (r_state == ST_DRAIN) && w_pop && r_head.frame_last && !i_abort;

    assign w_new.dat        = i_ram_dout;
    assign w_new.col        = r_pend_s;
    assign w_new.col_last   = r_pend_col_last;
    assign w_new.frame_last = r_pend_frame_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_issue && w_last_rd) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (i_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Column walk without a multiplier: stride down a column, then restart at the next sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s    <= '0;
            r_c    <= '0;
            r_addr <= '0;
        end else if (w_start) begin
            r_s    <= '0;
            r_c    <= '0;
            r_addr <= '0;
        end else if (w_issue) begin
            if (r_c == C_LAST) begin
                r_c <= '0;
                if (!w_last_rd) begin
                    r_s    <= r_s + S_ONE;
                    r_addr <= ADDR_WIDTH'(r_s) + A_ONE;
                end
            end else begin
                r_c    <= r_c + C_ONE;
                r_addr <= r_addr + A_STEP;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight        <= 1'b0;
            r_pend_s          <= '0;
            r_pend_col_last   <= 1'b0;
            r_pend_frame_last <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pend_s          <= r_s;
                r_pend_col_last   <= (r_c == C_LAST);
                r_pend_frame_last <= w_last_rd;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_h_vld <= 1'b0;
            r_t_vld <= 1'b0;
        end else if (i_abort) begin
            r_h_vld <= 1'b0;
            r_t_vld <= 1'b0;
        end else if (w_pop) begin
            if (r_t_vld) begin
                r_head  <= r_tail;
                r_t_vld <= w_push;
                if (w_push) r_tail <= w_new;
            end else if (w_push) begin
                r_head <= w_new;
            end else begin
                r_h_vld <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_h_vld) begin
                r_head  <= w_new;
                r_h_vld <= 1'b1;
            end else begin
                r_tail  <= w_new;
                r_t_vld <= 1'b1;
            end
        end
    end

    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = w_done;
    assign o_ram_en       = w_issue;
    assign o_ram_addr     = r_addr;
    assign o_m_data       = r_head.dat;
    assign o_m_valid      = r_h_vld;
    assign o_m_col_last   = r_head.col_last;
    assign o_m_frame_last = r_head.frame_last;
    assign o_m_col_idx    = r_head.col;

endmodule
